// File: rtl/seg7_display_arbiter_pkg.sv
// Shared types and constants for the 7-segment display arbiter.
package seg7_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } state_t;

    // Active-low segments: all ones turns every segment and the dp off.
    localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/seg7_display_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request scanning upward
// from the pointer, wrapping modulo NUM_REQ.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_rr_ptr,
    output logic [IDX_W-1:0]   o_winner,
    output logic               o_valid
);

    // Scan farthest-from-pointer first so the nearest set request is written last and wins.
    always_comb begin
        int w_k;
        // NOTE: every output gets a default before any conditional write, otherwise
        // paths that skip an assignment infer a latch.
        o_winner = '0;
        o_valid  = 1'b0;
        w_k      = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_k = int'(i_rr_ptr) + i;
            if (w_k >= NUM_REQ) begin
                w_k = w_k - NUM_REQ;
            end
            if (i_req[IDX_W'(w_k)]) begin
                o_winner = IDX_W'(w_k);
                o_valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg7_display_arbiter.sv
// Time-shares one 7-segment drive between NUM_REQ pattern sources using
// round-robin slices of SLICE_CYCLES separated by BLANK_CYCLES of all-off.
// Optional feature macro: BRIGHTNESS_PWM_EN adds a bright[2:0] input that
// duty-cycles the shown pattern within each slice.
module seg7_display_arbiter
    import seg7_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int SLICE_CYCLES = 1000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] pat_flat,
`ifdef BRIGHTNESS_PWM_EN
    input  logic [2:0]           bright,
`endif
    output logic [NUM_REQ-1:0]   gnt,
    output logic                 done,
    output logic [7:0]           seg_out,
    output logic                 busy
);

    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int CNT_MAX = (SLICE_CYCLES > BLANK_CYCLES) ? SLICE_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SLICE_LOAD = CNT_W'(SLICE_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_rr_ptr;
    logic [IDX_W-1:0]     r_gnt_idx;
    logic [NUM_REQ-1:0]   r_gnt;
    logic                 r_done;
    logic [7:0]           r_seg;

    state_t               w_state_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [IDX_W-1:0]     w_rr_ptr_nxt;
    logic [IDX_W-1:0]     w_gnt_idx_nxt;
    logic [NUM_REQ-1:0]   w_gnt_nxt;
    logic                 w_done_nxt;
    logic [7:0]           w_seg_nxt;
    logic                 w_start;
    logic [IDX_W-1:0]     w_winner;
    logic                 w_win_valid;
    logic [7:0]           w_pat;

`ifdef BRIGHTNESS_PWM_EN
    logic [2:0]           r_pwm_cnt;
    logic [2:0]           w_pwm_nxt;
`endif

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_picker (
        .i_req    (req),
        .i_rr_ptr (r_rr_ptr),
        .o_winner (w_winner),
        .o_valid  (w_win_valid)
    );

    // Live pattern of the currently granted source.
    always_comb begin
        w_pat = SEG_BLANK;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_gnt_idx == IDX_W'(i)) begin
                w_pat = pat_flat[8*i +: 8];
            end
        end
    end

    // Next-state and next-output logic; enable low overrides every state.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_rr_ptr_nxt  = r_rr_ptr;
        w_gnt_idx_nxt = r_gnt_idx;
        w_gnt_nxt     = '0;
        w_done_nxt    = 1'b0;
        w_seg_nxt     = SEG_BLANK;
        w_start       = 1'b0;
`ifdef BRIGHTNESS_PWM_EN
        w_pwm_nxt     = r_pwm_cnt;
`endif
        if (!enable) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_start = w_win_valid;
                end
                SHOW: begin
                    if (r_cnt == '0) begin
                        // Full slice, even if the request drops on this same cycle.
                        w_done_nxt  = 1'b1;
                        w_state_nxt = BLANK;
                        w_cnt_nxt   = BLANK_LOAD;
                    end else if (!req[r_gnt_idx]) begin
                        w_state_nxt = BLANK;
                        w_cnt_nxt   = BLANK_LOAD;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                        w_gnt_nxt = r_gnt;
`ifdef BRIGHTNESS_PWM_EN
                        w_seg_nxt = (r_pwm_cnt <= bright) ? w_pat : SEG_BLANK;
                        w_pwm_nxt = r_pwm_cnt + 3'd1;
`else
                        w_seg_nxt = w_pat;
`endif
                    end
                end
                BLANK: begin
                    if (r_cnt == '0) begin
                        w_start     = w_win_valid;
                        w_state_nxt = IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase

            // The pointer moves past the winner as soon as it is granted, so a
            // slice cut short by enable going low still hands over fairly.
            if (w_start) begin
                w_state_nxt            = SHOW;
                w_cnt_nxt              = SLICE_LOAD;
                w_gnt_idx_nxt          = w_winner;
                w_gnt_nxt              = '0;
                w_gnt_nxt[w_winner]    = 1'b1;
                w_rr_ptr_nxt           = (int'(w_winner) == NUM_REQ - 1) ? '0 : w_winner + 1'b1;
`ifdef BRIGHTNESS_PWM_EN
                w_pwm_nxt              = 3'd0;
`endif
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: clocked state always uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Counter, pointer and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_rr_ptr  <= '0;
            r_gnt_idx <= '0;
            r_gnt     <= '0;
            r_done    <= 1'b0;
            r_seg     <= SEG_BLANK;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_rr_ptr  <= w_rr_ptr_nxt;
            r_gnt_idx <= w_gnt_idx_nxt;
            r_gnt     <= w_gnt_nxt;
            r_done    <= w_done_nxt;
            r_seg     <= w_seg_nxt;
        end
    end

`ifdef BRIGHTNESS_PWM_EN
    // PWM phase within the current slice.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm_cnt <= 3'd0;
        end else begin
            r_pwm_cnt <= w_pwm_nxt;
        end
    end
`endif

    assign gnt     = r_gnt;
    assign done    = r_done;
    assign seg_out = r_seg;
    assign busy    = (r_state != IDLE);

endmodule
